rvx_core_bus_arbiter: RTL
=========================

Name: rvx_core_bus_arbiter

Overview:
- Merges the core's instruction bus and data bus onto one shared memory port, so a single-ported memory or interconnect can serve the whole core.
- Both core buses stall on one shared clock enable. The core may issue a fetch and a load/store in the same cycle and expects both responses in the same cycle.
- The arbiter therefore accepts a request group, serves its members one after another on the memory port, buffers the early result, and releases all responses together.

Parameters:
- IBUS_FIRST, 0: order within a two-request group. 0 = data bus served first; 1 = instruction bus served first.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ibus_address  in  32  fetch address
- ibus_rrequest  in  1  fetch request; held stable until response
- ibus_rdata  out  32  fetch data
- ibus_rresponse  out  1  fetch complete
- dbus_address  in  32  load/store address, word-aligned
- dbus_rrequest  in  1  load request
- dbus_wrequest  in  1  store request
- dbus_wdata  in  32  store data
- dbus_wstrobe  in  4  store byte enables
- dbus_rdata  out  32  load data
- dbus_rresponse  out  1  load complete
- dbus_wresponse  out  1  store complete
- mem_address  out  32  shared port address
- mem_rrequest  out  1  shared read request
- mem_wrequest  out  1  shared write request
- mem_wdata  out  32  shared write data
- mem_wstrobe  out  4  shared byte enables
- mem_rdata  in  32  shared read data
- mem_rresponse  in  1  read complete; asserted in a cycle after the request
- mem_wresponse  in  1  write complete

Behaviour:
- Bus protocol on every port:
  - A request is asserted with its address and data.
  - The requester holds all request signals stable until it sees the response.
  - The response comes one or more cycles after the request was first presented.
- States: IDLE, SERVE_A, SERVE_B, all with registered state.
  - SERVE_A serves the first group member; SERVE_B serves the second.
  - Registered per-group data: pend_i, pend_d, d_is_write, and buffer buf_rdata[31:0].
- Accept condition: state==IDLE, or the current group completes this cycle.
  - Latch pend_i=ibus_rrequest and pend_d=dbus_rrequest|dbus_wrequest.
  - If dbus_wrequest is high, treat the data access as a write and ignore dbus_rrequest.
  - If either is pending, forward the first member (per IBUS_FIRST) to mem_* combinationally in the same cycle, with zero added latency, and go to SERVE_A.
  - If neither is pending, stay in IDLE.
- SERVE_A/SERVE_B: mem_* follow the member being served. Its request stays asserted until the matching response arrives.
  - "Matching response" means mem_rresponse for a read and mem_wresponse for a write.
  - The non-matching response and any response while in IDLE are ignored.
- Completion of the first member with a second member pending:
  - Capture mem_rdata into buf_rdata.
  - In the same cycle, forward the second member (back-to-back) and go to SERVE_B.
  - No response goes to either master yet.
- Release cycle: the cycle in which the last member of the group completes.
  - Assert ibus_rresponse if pend_i.
  - Assert dbus_rresponse if pend_d and the access was a read; assert dbus_wresponse if pend_d and the access was a write.
  - The completing member's rdata is mem_rdata passed through; the earlier member's rdata is buf_rdata.
  - The accept condition holds in this same cycle, so a new group may start with no bubble.
- Outside release cycles: all *_response outputs are 0, and ibus_rdata/dbus_rdata pass mem_rdata through.
- When no member is being forwarded: mem_rrequest=mem_wrequest=0, and mem_address, mem_wdata and mem_wstrobe are 0.
- Latency:
  - A lone request costs exactly the memory latency.
  - A pair costs the sum of both memory latencies. Minimum is 2 cycles for a pair with single-cycle memory.
- Never forward ibus as a write. mem_wrequest is driven only from the data bus.
- Reset (reset_n=0 on a clock edge), including mid-transaction:
  - State returns to IDLE and pend_* and d_is_write are cleared; buf_rdata is reset to 0.
  - All response and request outputs are 0 while reset_n=0.
  - A late memory response after reset is ignored.
- No combinational path from mem_*response to mem_*request other than back-to-back forwarding in a completion cycle. Forwarding uses master inputs only, so no loop exists.

Test Plan:
- Lone fetch: ibus_rrequest=1 at 0x100, 1-cycle memory returning 0x00000013 -> mem_address=0x100 in the same cycle; ibus_rresponse=1 with rdata 0x13 next cycle; dbus_*response=0.
- Lone store: dbus_wrequest=1 to 0x2000, wdata 0xDEADBEEF, wstrobe 0xF -> mem_wrequest=1 with those values; dbus_wresponse after mem_wresponse; mem_rrequest=0.
- Simultaneous load at 0x40 and fetch at 0x0, IBUS_FIRST=0, 1-cycle memory -> mem serves 0x40 then 0x0 back-to-back. Both responses are asserted together 2 cycles after the request; dbus_rdata comes from buf_rdata.
- The same pair with 3 wait states on the first access -> the second request is forwarded only in the cycle of the first response; no master response occurs before the final release.
- Continuous fetch+load stream -> a new group is accepted in each release cycle with no idle cycle on mem_*; also verify with IBUS_FIRST=1.
- Reset asserted while in SERVE_B, followed by a stray mem_rresponse -> all outputs are 0, state returns to IDLE, and no master response is generated.

Source files
------------

// File: rtl/rvx_core_bus_arbiter.sv
// Merges the core's instruction and data buses onto one shared memory port.
// The fetch and the load/store of a group are served in turn, and both responses are released in the same cycle.
module rvx_core_bus_arbiter #(
  parameter bit IBUS_FIRST = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] ibus_address,
  input  logic        ibus_rrequest,
  output logic [31:0] ibus_rdata,
  output logic        ibus_rresponse,
  input  logic [31:0] dbus_address,
  input  logic        dbus_rrequest,
  input  logic        dbus_wrequest,
  input  logic [31:0] dbus_wdata,
  input  logic [3:0]  dbus_wstrobe,
  output logic [31:0] dbus_rdata,
  output logic        dbus_rresponse,
  output logic        dbus_wresponse,
  output logic [31:0] mem_address,
  output logic        mem_rrequest,
  output logic        mem_wrequest,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rresponse,
  input  logic        mem_wresponse,
  output logic [1:0]  dbg_state
);

  // Every bus follows one handshake: a request holds its address and data
  // stable until the matching response. The response arrives one or more
  // cycles after the request is first presented. dbg_state: 0=IDLE,
  // 1=SERVE_A, 2=SERVE_B.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  state_t      state;
  logic        pend_i;
  logic        pend_d;
  logic        d_is_write;
  logic [31:0] buf_rdata;

  logic new_i, new_d, new_w, new_first_d;
  logic both, cur_is_d, cur_done, last_member;
  logic release_now, advance, accept;
  logic fwd_en, fwd_is_d, fwd_w;

  assign new_i       = ibus_rrequest;
  assign new_d       = dbus_rrequest | dbus_wrequest;
  assign new_w       = dbus_wrequest;
  assign new_first_d = new_d && (!new_i || !IBUS_FIRST);
  assign both        = pend_i & pend_d;

  always_comb begin
    cur_is_d = 1'b0;
    case (state)
      SERVE_A: cur_is_d = pend_d && (!pend_i || !IBUS_FIRST);
      SERVE_B: cur_is_d = IBUS_FIRST;
      default: cur_is_d = 1'b0;
    endcase
  end

  // Only the response matching the served access counts; the other is ignored.
  assign cur_done    = reset_n && (state != IDLE) &&
                       ((cur_is_d && d_is_write) ? mem_wresponse : mem_rresponse);
  assign last_member = (state == SERVE_B) || !both;
  assign release_now = cur_done && last_member;
  assign advance     = cur_done && (state == SERVE_A) && both;
  assign accept      = reset_n && ((state == IDLE) || release_now);

  // Forwarding uses only master inputs, which are held stable while pending.
  always_comb begin
    fwd_en   = 1'b0;
    fwd_is_d = 1'b0;
    fwd_w    = 1'b0;
    if (accept) begin
      fwd_en   = new_i | new_d;
      fwd_is_d = new_first_d;
      fwd_w    = new_w;
    end else if (advance) begin
      fwd_en   = 1'b1;
      fwd_is_d = IBUS_FIRST;
      fwd_w    = d_is_write;
    end else if (reset_n && (state != IDLE)) begin
      fwd_en   = 1'b1;
      fwd_is_d = cur_is_d;
      fwd_w    = d_is_write;
    end
  end

  assign mem_rrequest = fwd_en && !(fwd_is_d && fwd_w);
  assign mem_wrequest = fwd_en && fwd_is_d && fwd_w;
  assign mem_address  = !fwd_en ? 32'd0 : (fwd_is_d ? dbus_address : ibus_address);
  assign mem_wdata    = mem_wrequest ? dbus_wdata : 32'd0;
  assign mem_wstrobe  = mem_wrequest ? dbus_wstrobe : 4'd0;

  assign ibus_rresponse = release_now && pend_i;
  assign dbus_rresponse = release_now && pend_d && !d_is_write;
  assign dbus_wresponse = release_now && pend_d && d_is_write;

  // The member finishing last passes mem_rdata through; the earlier one comes from the buffer.
  assign ibus_rdata = (release_now && both && cur_is_d)  ? buf_rdata : mem_rdata;
  assign dbus_rdata = (release_now && both && !cur_is_d) ? buf_rdata : mem_rdata;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      pend_i     <= 1'b0;
      pend_d     <= 1'b0;
      d_is_write <= 1'b0;
      buf_rdata  <= 32'd0;
    end else if (accept) begin
      pend_i     <= new_i;
      pend_d     <= new_d;
      d_is_write <= new_w;
      state      <= (new_i | new_d) ? SERVE_A : IDLE;
    end else if (advance) begin
      buf_rdata <= mem_rdata;
      state     <= SERVE_B;
    end
  end

  assign dbg_state = state;

endmodule
